// File: rtl/lfsr_sync_checker.sv
// -----------------------------------------------------------------------------
// lfsr_sync_checker
//
// Purpose:
//   Synchronises to a serial PRBS stream produced by the 7-bit generator
//   b(n) = b(n-1) ^ b(n-7). A 7-bit window holds the last accepted bits
//   (newest in bit 6) and predicts the next bit. The checker fills the window
//   (HUNT), confirms LOCK_CNT consecutive correct predictions (VERIFY), then
//   flywheels on its own predictions (LOCKED) and flags received mismatches.
//   LOSS_CNT consecutive mismatches while locked send it back to HUNT.
//
// Parameters:
//   LOCK_CNT  consecutive correct predictions needed to lock (1..255)
//   LOSS_CNT  consecutive mismatches in LOCKED that drop lock (1..255)
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   i_valid    qualifies i_bit; nothing but the error counter clear acts
//              on cycles without it
//   i_bit      received serial bit
//   i_clr_cnt  clears o_err_cnt (wins over a coincident mismatch)
//   o_locked   high while in LOCKED (registered)
//   o_err      one-cycle pulse per mismatch seen in LOCKED (registered)
//   o_err_cnt  saturating count of LOCKED mismatches
//   o_state    the 7-bit window register
//
// Configuration:
//   LFSR_SYNC_CHECKER_ERRCNT_EN  when defined, builds the 16-bit saturating
//   error counter and honours i_clr_cnt; otherwise o_err_cnt is tied to zero
//   and i_clr_cnt is ignored.
// -----------------------------------------------------------------------------
module lfsr_sync_checker #(
  parameter int unsigned LOCK_CNT = 14,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_bit,
  input  logic        i_clr_cnt,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_err_cnt,
  output logic [6:0]  o_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

  state_e      state_q, state_d;
  logic [6:0]  r_q, r_d;
  logic [2:0]  fill_q, fill_d;
  logic [7:0]  match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  logic        pred;
  logic        hit;
  logic        lock_mismatch;

  assign pred          = r_q[6] ^ r_q[0];
  assign hit           = (i_bit == pred);
  assign lock_mismatch = i_valid && (state_q == LOCKED) && !hit;

  // State register and all datapath flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= HUNT;
      r_q      <= 7'h00;
      fill_q   <= 3'd0;
      match_q  <= 8'd0;
      miss_q   <= 8'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counter logic; only accepted bits move anything.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (i_valid) begin
      case (state_q)
        HUNT: begin
          r_d    = {i_bit, r_q[6:1]};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd6) begin
            state_d = VERIFY;
            match_d = 8'd0;
          end
        end
        VERIFY: begin
          r_d = {i_bit, r_q[6:1]};
          // An all-zero window predicts zero forever, so it never counts.
          if (hit && (r_q != 7'h00)) begin
            if ((match_q + 8'd1) == LOCK_TGT) begin
              state_d = LOCKED;
              match_d = 8'd0;
              miss_d  = 8'd0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = 8'd0;
          end
        end
        LOCKED: begin
          // Flywheel: the window advances on its own prediction so a
          // corrupted received bit never pollutes it.
          r_d = {pred, r_q[6:1]};
          if (hit) begin
            miss_d = 8'd0;
          end else if ((miss_q + 8'd1) == LOSS_TGT) begin
            state_d = HUNT;
            fill_d  = 3'd0;
            match_d = 8'd0;
            miss_d  = 8'd0;
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = 3'd0;
          match_d = 8'd0;
          miss_d  = 8'd0;
        end
      endcase
    end
  end

  // Output decode, registered so outputs move one cycle after the deciding bit.
  always_comb begin
    locked_d = (state_d == LOCKED);
    err_d    = lock_mismatch;
  end

`ifdef LFSR_SYNC_CHECKER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Clear has priority; the counter holds once it reaches all ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_clr_cnt) begin
      err_cnt_d = 16'h0000;
    end else if (lock_mismatch && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  logic unused_clr_cnt;

  assign unused_clr_cnt = i_clr_cnt;
  assign o_err_cnt      = 16'h0000;
`endif

  assign o_locked = locked_q;
  assign o_err    = err_q;
  assign o_state  = r_q;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_sync_checker
//
// Directed bench for lfsr_sync_checker. A small generator model produces the
// PRBS stream, a clean-bit history gives the expected window, and a counter
// model gives the expected error count. A second instance with LOCK_CNT=1 and
// LOSS_CNT=255 exercises error counter saturation when the counter is built.
// -----------------------------------------------------------------------------
module tb_lfsr_sync_checker;

`ifdef LFSR_SYNC_CHECKER_ERRCNT_EN
   localparam bit ERRCNT_EN = 1'b1;
`else
   localparam bit ERRCNT_EN = 1'b0;
`endif

   logic        clock;
   logic        rstN;
   logic        valid;
   logic        bitIn;
   logic        clrCnt;
   logic        locked;
   logic        err;
   logic [15:0] errCnt;
   logic [6:0]  state;

   logic [6:0]  gen;
   logic [6:0]  hist;
   logic [15:0] expCnt;

   int          checkCount;
   int          errorCount;

   lfsr_sync_checker #(
      .LOCK_CNT(14),
      .LOSS_CNT(4)
   ) dut (
      .i_clk    (clock),
      .i_rst_n  (rstN),
      .i_valid  (valid),
      .i_bit    (bitIn),
      .i_clr_cnt(clrCnt),
      .o_locked (locked),
      .o_err    (err),
      .o_err_cnt(errCnt),
      .o_state  (state)
   );

`ifdef LFSR_SYNC_CHECKER_ERRCNT_EN
   logic        valid2;
   logic        bit2;
   logic        clr2;
   logic        locked2;
   logic        err2;
   logic [15:0] errCnt2;
   logic [6:0]  state2;
   logic [6:0]  gen2;
   logic [6:0]  hist2;

   lfsr_sync_checker #(
      .LOCK_CNT(1),
      .LOSS_CNT(255)
   ) dutSat (
      .i_clk    (clock),
      .i_rst_n  (rstN),
      .i_valid  (valid2),
      .i_bit    (bit2),
      .i_clr_cnt(clr2),
      .o_locked (locked2),
      .o_err    (err2),
      .o_err_cnt(errCnt2),
      .o_state  (state2)
   );
`endif

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs and returns just after the sampling edge.
   task automatic applyStimulus(input logic v, input logic b, input logic c);
      valid  = v;
      bitIn  = b;
      clrCnt = c;
      @(posedge clock);
      #1;
   endtask

   // Sends the next generator bit, optionally inverted, and updates the models.
   task automatic sendBit(input logic inv, input logic c);
      logic cleanBit;
      cleanBit = gen[0];
      applyStimulus(1'b1, cleanBit ^ inv, c);
      hist = {cleanBit, hist[6:1]};
      gen  = {gen[6] ^ gen[0], gen[6:1]};
   endtask

   // Holds reset for two edges and clears the window and counter models.
   task automatic applyReset();
      rstN = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      rstN   = 1'b1;
      hist   = 7'h00;
      expCnt = 16'h0000;
   endtask

   function automatic logic [15:0] cntModel(input logic [15:0] c);
      return ERRCNT_EN ? c : 16'h0000;
   endfunction

`ifdef LFSR_SYNC_CHECKER_ERRCNT_EN
   // Same as sendBit but for the saturation instance.
   task automatic sendBit2(input logic inv);
      logic cleanBit;
      cleanBit = gen2[0];
      valid2   = 1'b1;
      bit2     = cleanBit ^ inv;
      @(posedge clock);
      #1;
      hist2 = {cleanBit, hist2[6:1]};
      gen2  = {gen2[6] ^ gen2[0], gen2[6:1]};
   endtask
`endif

   // Main directed sequence.
   initial begin
      checkCount = 0;
      errorCount = 0;
      rstN       = 1'b1;
      valid      = 1'b0;
      bitIn      = 1'b0;
      clrCnt     = 1'b0;
      gen        = 7'h01;
      hist       = 7'h00;
      expCnt     = 16'h0000;
`ifdef LFSR_SYNC_CHECKER_ERRCNT_EN
      valid2 = 1'b0;
      bit2   = 1'b0;
      clr2   = 1'b0;
      gen2   = 7'h01;
      hist2  = 7'h00;
`endif

      // Reset values.
      applyReset();
      checkOutput("rst_locked", {15'd0, locked}, 16'd0);
      checkOutput("rst_err", {15'd0, err}, 16'd0);
      checkOutput("rst_errcnt", errCnt, 16'd0);
      checkOutput("rst_state", {9'd0, state}, 16'd0);

      // Acquisition from seed 01: 7 fill bits plus 14 matches.
      for (int i = 1; i <= 20; i++) sendBit(1'b0, 1'b0);
      checkOutput("acq_pre_lock", {15'd0, locked}, 16'd0);
      sendBit(1'b0, 1'b0);
      checkOutput("acq_lock", {15'd0, locked}, 16'd1);
      checkOutput("acq_state", {9'd0, state}, {9'd0, hist});

      // Tracking while locked.
      for (int i = 0; i < 5; i++) begin
         sendBit(1'b0, 1'b0);
         checkOutput("track_state", {9'd0, state}, {9'd0, hist});
         checkOutput("track_err", {15'd0, err}, 16'd0);
      end

      // Invalid cycles with wrong bits must change nothing.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, ~gen[0], 1'b0);
         checkOutput("gate_state", {9'd0, state}, {9'd0, hist});
         checkOutput("gate_err", {15'd0, err}, 16'd0);
      end

      // Single corrupted bit: one pulse, lock held, window stays clean.
      sendBit(1'b1, 1'b0);
      expCnt++;
      checkOutput("single_err", {15'd0, err}, 16'd1);
      checkOutput("single_cnt", errCnt, cntModel(expCnt));
      checkOutput("single_locked", {15'd0, locked}, 16'd1);
      checkOutput("single_state", {9'd0, state}, {9'd0, hist});
      sendBit(1'b0, 1'b0);
      checkOutput("single_pulse_end", {15'd0, err}, 16'd0);

      // Counter clear on an idle cycle.
      applyStimulus(1'b0, 1'b0, 1'b1);
      expCnt = 16'h0000;
      checkOutput("clr_idle", errCnt, cntModel(expCnt));

      // Four consecutive corrupted bits drop lock on the fourth.
      for (int j = 1; j <= 4; j++) begin
         sendBit(1'b1, 1'b0);
         expCnt++;
         checkOutput("loss_err", {15'd0, err}, 16'd1);
         checkOutput("loss_locked", {15'd0, locked}, (j < 4) ? 16'd1 : 16'd0);
      end
      checkOutput("loss_cnt", errCnt, cntModel(expCnt));

      // Relock needs a full 21 clean bits.
      for (int i = 1; i <= 20; i++) sendBit(1'b0, 1'b0);
      checkOutput("relock_pre", {15'd0, locked}, 16'd0);
      sendBit(1'b0, 1'b0);
      checkOutput("relock", {15'd0, locked}, 16'd1);
      checkOutput("relock_state", {9'd0, state}, {9'd0, hist});

      // Clear coincident with a counted mismatch: clear wins, pulse still fires.
      sendBit(1'b1, 1'b1);
      expCnt = 16'h0000;
      checkOutput("clr_coinc_err", {15'd0, err}, 16'd1);
      checkOutput("clr_coinc_cnt", errCnt, cntModel(expCnt));
      sendBit(1'b0, 1'b0);

      // Reset while locked discards lock and window.
      applyReset();
      checkOutput("rst_lock_locked", {15'd0, locked}, 16'd0);
      checkOutput("rst_lock_state", {9'd0, state}, 16'd0);

      // All-zero stream never locks and never flags.
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("zero_locked", {15'd0, locked}, 16'd0);
         checkOutput("zero_err", {15'd0, err}, 16'd0);
      end

      // Valid toggling each cycle: lock after 21 valid bits.
      applyReset();
      for (int i = 1; i <= 20; i++) begin
         sendBit(1'b0, 1'b0);
         applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      end
      checkOutput("toggle_pre", {15'd0, locked}, 16'd0);
      sendBit(1'b0, 1'b0);
      checkOutput("toggle_lock", {15'd0, locked}, 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("toggle_hold", {15'd0, locked}, 16'd1);

      // Reset at VERIFY match 10 forces a full reacquire.
      applyReset();
      for (int i = 1; i <= 17; i++) sendBit(1'b0, 1'b0);
      checkOutput("midv_pre", {15'd0, locked}, 16'd0);
      applyReset();
      checkOutput("midv_state", {9'd0, state}, 16'd0);
      for (int i = 1; i <= 20; i++) sendBit(1'b0, 1'b0);
      checkOutput("midv_relock_pre", {15'd0, locked}, 16'd0);
      sendBit(1'b0, 1'b0);
      checkOutput("midv_relock", {15'd0, locked}, 16'd1);

      valid  = 1'b0;
      clrCnt = 1'b0;

`ifdef LFSR_SYNC_CHECKER_ERRCNT_EN
      // Saturation: lock the second instance, then 65540 mismatches with a
      // clean bit every 254 so lock is never lost.
      for (int i = 1; i <= 8; i++) sendBit2(1'b0);
      checkOutput("sat_lock", {15'd0, locked2}, 16'd1);
      begin
         int m;
         m = 0;
         while (m < 65540) begin
            for (int k = 0; k < 254 && m < 65540; k++) begin
               sendBit2(1'b1);
               m++;
               if (m == 65535) checkOutput("sat_reach", errCnt2, 16'hFFFF);
            end
            if (m == 65540) checkOutput("sat_last_err", {15'd0, err2}, 16'd1);
            sendBit2(1'b0);
         end
      end
      checkOutput("sat_hold", errCnt2, 16'hFFFF);
      checkOutput("sat_locked", {15'd0, locked2}, 16'd1);
      checkOutput("sat_state", {9'd0, state2}, {9'd0, hist2});
      valid2 = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/lfsr_sync_checker.md
LFSR_SYNC_CHECKER -- requirements
Module: lfsr_sync_checker

Interface
REQ-001 Parameter LOCK_CNT, default 14, SHALL set the number of consecutive correct predicted bits needed to declare lock (legal range 1..255).
REQ-002 Parameter LOSS_CNT, default 4, SHALL set the number of consecutive mismatches in LOCKED that drop lock (legal range 1..255).
REQ-003 Port i_clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port i_rst_n, input, 1, SHALL be a synchronous, active-low reset.
REQ-005 Port i_valid, input, 1, SHALL qualify i_bit; no state changes on cycles with i_valid=0, except i_clr_cnt.
REQ-006 Port i_bit, input, 1, SHALL be the received serial bit: the generator's state[0] sampled once per generator step.
REQ-007 Port i_clr_cnt, input, 1, SHALL clear o_err_cnt.
REQ-008 Port o_locked, output, 1, SHALL be high only in the LOCKED state.
REQ-009 Port o_err, output, 1, SHALL give a one-cycle pulse per mismatch detected in LOCKED.
REQ-010 Port o_err_cnt, output, 16, SHALL count LOCKED mismatches, saturating at 16'hFFFF.
REQ-011 Port o_state, output, 7, SHALL be the 7-bit window register r.

Function
REQ-012 Window r[6:0] SHALL hold the last 7 accepted bits, newest in r[6]; prediction p = r[6] ^ r[0] (recurrence b(n) = b(n-1) ^ b(n-7)).
REQ-013 On each accepted bit, r SHALL update to {x, r[6:1]}. In HUNT and VERIFY, x = i_bit; in LOCKED, x = p (flywheel, so a corrupted bit does not corrupt r).
REQ-014 State HUNT: a fill counter SHALL count accepted bits 0..7. After the 7th bit the state SHALL change to VERIFY and the match counter SHALL be 0.
REQ-015 State VERIFY: when i_bit == p and r != 0, the match counter SHALL increment. When it reaches LOCK_CNT, the next state SHALL be LOCKED.
REQ-016 VERIFY: a mismatch, or r == 7'h00, SHALL reset the match counter to 0 and SHALL stay in VERIFY (no refill needed); the all-zero stream SHALL never lock.
REQ-017 State LOCKED: a match SHALL clear the miss counter.
REQ-018 LOCKED: a mismatch SHALL increment the miss counter, pulse o_err and increment o_err_cnt. On reaching LOSS_CNT it SHALL go to HUNT with fill counter 0.
REQ-019 All outputs SHALL be registered; o_locked/o_err SHALL change the cycle after the deciding bit is sampled (1-cycle latency).
REQ-020 If i_clr_cnt and a counted mismatch fall in the same cycle, clear SHALL win (o_err_cnt = 0).
REQ-021 o_err_cnt at 16'hFFFF SHALL hold on further mismatches while o_err still pulses.

Reset
REQ-022 While i_rst_n=0 at a clock edge, the block SHALL set: state HUNT, r = 7'h00, fill, match and miss counters 0, o_locked=0, o_err=0, o_err_cnt=0.
REQ-023 Reset in any state, including mid-VERIFY or LOCKED, SHALL discard all history; reacquisition SHALL need 7 + LOCK_CNT fresh bits.

Configuration
REQ-024 With macro LFSR_SYNC_CHECKER_ERRCNT_EN defined, o_err_cnt and i_clr_cnt SHALL behave as above.
REQ-025 Without LFSR_SYNC_CHECKER_ERRCNT_EN, o_err_cnt SHALL be constant 16'h0000, i_clr_cnt ignored, no counter flops; o_err unaffected.

Verification
REQ-026 Generator seed 7'h01, continuous i_valid, LOCK_CNT=14 -> o_locked rises the cycle after the 21st bit; o_state tracks generator state every cycle thereafter.
REQ-027 Locked, invert one bit -> o_err single pulse, o_err_cnt=1, o_locked stays 1, o_state remains equal to generator state.
REQ-028 Locked, invert 4 consecutive bits (LOSS_CNT=4) -> o_err_cnt=4, o_locked falls after 4th, relock after 21 further clean bits.
REQ-029 200 zero bits -> o_locked never asserts; o_err never pulses.
REQ-030 i_valid toggling 1/0 each cycle -> lock after 21 valid bits (about 42 cycles); reset asserted at VERIFY match 10 -> full 21-bit reacquire.
REQ-031 i_clr_cnt coincident with mismatch -> o_err_cnt=0; 65540 mismatches -> saturates 16'hFFFF; macro undefined -> o_err_cnt always 0.
